load_arbiter: RTL and testbench
===============================

Name: load_arbiter

Overview:
- Shares the single image-load unit among N_REQ layer controllers (e.g. conv layer, pool layer), each of which drives a loadEnable/loadAddr/loadSize/loadDone style request.
- Round-robin arbitration: one load in flight at a time, with the winner's address and size latched.
- Only the completion pulse is routed back to the owning requester. The loadOut data bus is broadcast by the top level and does not pass through this block.

Parameters:
- N_REQ, 2, number of requesters (2..8)
- DATA_SZ, 16, width of the size field
- ADDR_SZ, 16, width of the address field
- WD_LIMIT, 4096, watchdog cycle limit (used only with LOAD_ARB_WATCHDOG_EN)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req_enable  in  N_REQ  per-requester level request; held high until its req_done is seen
- req_addr  in  N_REQ*ADDR_SZ  packed addresses; requester i occupies [i*ADDR_SZ +: ADDR_SZ]
- req_size  in  N_REQ*DATA_SZ  packed sizes; same packing as req_addr
- req_done  out  N_REQ  one-cycle completion pulse to the owner
- grant  out  N_REQ  one-hot current owner; all zero when idle
- loadEnable  out  1  request to the load unit
- loadAddr  out  ADDR_SZ  latched address of the owner
- loadSize  out  DATA_SZ  latched size of the owner
- loadDone  in  1  load unit completion
- busy  out  1  high in any state except IDLE
- wd_error  out  1  one-cycle watchdog pulse; tied 0 when the feature is absent

Behaviour:
- Reset (asynchronous, any state):
  - state=IDLE.
  - grant, req_done, loadEnable, busy, wd_error = 0.
  - loadAddr, loadSize = 0.
  - last_owner = N_REQ-1, so requester 0 has first priority.
- IDLE:
  - If any req_enable bit is set, select the first set bit scanning last_owner+1, last_owner+2, … modulo N_REQ.
  - Next edge: grant=onehot(winner), loadAddr/loadSize latched from the winner's slice, loadEnable=1, busy=1, state=BUSY.
  - Latency: request seen at edge N gives loadEnable high after edge N.
  - loadDone while IDLE is ignored.
- BUSY:
  - loadAddr/loadSize stay frozen even if the owner changes its inputs.
  - Other requests wait; their req_enable levels are simply sampled later.
  - On the edge where loadDone=1: loadEnable=0, req_done[owner]=1 for exactly one cycle, state=RELEASE.
- RELEASE:
  - req_done returns to 0 after one cycle.
  - grant is held until req_enable[owner]==0 is sampled. This prevents a stale level being re-granted.
  - On that edge: grant=0, busy=0, last_owner=owner, state=IDLE.
  - A new arbitration can begin on the following edge, so minimum spacing between two loads is 1 idle cycle.
- If the owner drops req_enable during BUSY, the load still completes and req_done is still pulsed. RELEASE then exits on its first cycle.
- Simultaneous requests:
  - Strict rotation, so no requester is granted twice while another is waiting.
  - Example with N_REQ=2, both held high: grants alternate 0,1,0,1.
- Exactly one grant bit is ever set. req_done is never asserted to a non-owner.
- State encoding: IDLE=0, BUSY=1, RELEASE=2 (2-bit register).

Optional Feature:
- Macro LOAD_ARB_WATCHDOG_EN.
- Defined:
  - A counter clears on entry to BUSY and increments each BUSY cycle without loadDone.
  - When it reaches WD_LIMIT-1: loadEnable=0, wd_error=1 for one cycle, req_done[owner]=1 for one cycle (abort, no data valid), state=RELEASE.
  - loadDone arriving on the same edge as expiry wins: normal completion, wd_error stays 0.
  - Counter resets asynchronously with reset.
- Undefined:
  - No counter is built and wd_error is tied to 0.
  - BUSY waits indefinitely for loadDone.

Test Plan:
- Reset mid-BUSY: req0 granted, assert reset for 1 cycle before loadDone → all outputs 0 immediately (asynchronously). Re-request from req1 only → grant=2'b10, loadAddr=req1 address.
- Single request: req_enable=2'b01, addr0=0x0100, size0=28 → next edge loadEnable=1, loadAddr=0x0100, loadSize=28, grant=01. loadDone pulsed 5 cycles later → req_done=01 for 1 cycle, loadEnable=0. Drop req0 → grant=00, busy=0.
- Contention: req_enable=2'b11 held, loadDone returned 3 cycles after each loadEnable → grant sequence 01,10,01,10, and loadAddr matches the owner's address each time.
- Address stability: req0 granted, addr0 changed 0x0100→0x0200 during BUSY → loadAddr stays 0x0100 until completion.
- Stale level: req0 keeps req_enable high for 4 cycles after req_done → grant stays 01 and no second loadEnable occurs. After req0 drops, req1 (pending) is granted next.
- Watchdog (macro defined, WD_LIMIT=16): no loadDone → wd_error and req_done[owner] pulse 16 cycles after loadEnable rose, loadEnable=0. Same setup with loadDone on cycle 16 → no wd_error.

Source files
------------

// File: rtl/load_arbiter.sv
// Round-robin arbiter sharing one image-load unit among N_REQ layer controllers.
// Optional load watchdog enabled by defining LOAD_ARB_WATCHDOG_EN.
module load_arbiter #(
   parameter int N_REQ    = 2,
   parameter int DATA_SZ  = 16,
   parameter int ADDR_SZ  = 16,
   parameter int WD_LIMIT = 4096
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [N_REQ-1:0]           req_enable,
   input  logic [N_REQ*ADDR_SZ-1:0]   req_addr,
   input  logic [N_REQ*DATA_SZ-1:0]   req_size,
   output logic [N_REQ-1:0]           req_done,
   output logic [N_REQ-1:0]           grant,
   output logic                       loadEnable,
   output logic [ADDR_SZ-1:0]         loadAddr,
   output logic [DATA_SZ-1:0]         loadSize,
   input  logic                       loadDone,
   output logic                       busy,
   output logic                       wd_error
);

   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY    = 2'd1,
      RELEASE = 2'd2
   } state_t;

   state_t             state, state_nxt;
   logic [IDX_W-1:0]   owner, owner_nxt;
   logic [IDX_W-1:0]   last_owner, last_owner_nxt;
   logic [N_REQ-1:0]   grant_nxt, req_done_nxt;
   logic               load_enable_nxt;
   logic [ADDR_SZ-1:0] load_addr_nxt;
   logic [DATA_SZ-1:0] load_size_nxt;
   logic               win_valid;
   logic [IDX_W-1:0]   win_idx;
   logic               wd_expire;

   logic [ADDR_SZ-1:0] addr_slot [N_REQ];
   logic [DATA_SZ-1:0] size_slot [N_REQ];

   for (genvar i = 0; i < N_REQ; i++) begin : g_slot
      assign addr_slot[i] = req_addr[i*ADDR_SZ +: ADDR_SZ];
      assign size_slot[i] = req_size[i*DATA_SZ +: DATA_SZ];
   end

   // Rotating priority: scan starts just after the previous owner.
   always_comb begin
      win_valid = 1'b0;
      win_idx   = '0;
      for (int i = 1; i <= N_REQ; i++) begin
         int cand;
         cand = int'(last_owner) + i;
         if (cand >= N_REQ) cand = cand - N_REQ;
         if (!win_valid && req_enable[IDX_W'(cand)]) begin
            win_valid = 1'b1;
            win_idx   = IDX_W'(cand);
         end
      end
   end

   // NOTE: every signal gets a default before the case so no path leaves it
   // unassigned; otherwise synthesis infers a latch to hold the old value.
   always_comb begin
      state_nxt       = state;
      owner_nxt       = owner;
      last_owner_nxt  = last_owner;
      grant_nxt       = grant;
      req_done_nxt    = '0;
      load_enable_nxt = loadEnable;
      load_addr_nxt   = loadAddr;
      load_size_nxt   = loadSize;
      unique case (state)
         IDLE: begin
            if (win_valid) begin
               state_nxt       = BUSY;
               owner_nxt       = win_idx;
               grant_nxt       = N_REQ'(1) << win_idx;
               load_enable_nxt = 1'b1;
               load_addr_nxt   = addr_slot[win_idx];
               load_size_nxt   = size_slot[win_idx];
            end
         end
         BUSY: begin
            // An aborted load still pulses req_done so the owner can move on.
            if (loadDone || wd_expire) begin
               state_nxt       = RELEASE;
               load_enable_nxt = 1'b0;
               req_done_nxt    = grant;
            end
         end
         RELEASE: begin
            // Hold ownership until the owner's stale level has dropped.
            if (!req_enable[owner]) begin
               state_nxt      = IDLE;
               grant_nxt      = '0;
               last_owner_nxt = owner;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values; blocking here would create order-dependent races.
   // NOTE: loadAddr/loadSize are plain registers, not memories, so they take the
   // async reset like the control flops and read as zero after reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         owner      <= '0;
         last_owner <= IDX_W'(N_REQ - 1);
         grant      <= '0;
         req_done   <= '0;
         loadEnable <= 1'b0;
         loadAddr   <= '0;
         loadSize   <= '0;
      end else begin
         state      <= state_nxt;
         owner      <= owner_nxt;
         last_owner <= last_owner_nxt;
         grant      <= grant_nxt;
         req_done   <= req_done_nxt;
         loadEnable <= load_enable_nxt;
         loadAddr   <= load_addr_nxt;
         loadSize   <= load_size_nxt;
      end
   end

   assign busy = (state != IDLE);

`ifdef LOAD_ARB_WATCHDOG_EN
   localparam int WD_W = $clog2(WD_LIMIT + 1);

   logic [WD_W-1:0] wd_cnt;

   assign wd_expire = (wd_cnt == WD_W'(WD_LIMIT - 1));

   // Held at zero outside BUSY, so every load starts counting from zero.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wd_cnt   <= '0;
         wd_error <= 1'b0;
      end else begin
         wd_error <= (state == BUSY) && !loadDone && wd_expire;
         if (state != BUSY)
            wd_cnt <= '0;
         else if (!loadDone && !wd_expire)
            wd_cnt <= wd_cnt + 1'b1;
      end
   end
`else
   assign wd_expire = 1'b0;
   assign wd_error  = 1'b0;
`endif

endmodule

// File: tb/tb_load_arbiter.sv
// Directed bench for load_arbiter (N_REQ=2, WD_LIMIT=16), covering both watchdog builds.
module tb_load_arbiter;

   logic        clk;
   logic        reset;
   logic [1:0]  req_enable;
   logic [15:0] addr0, addr1, size0, size1;
   logic [31:0] req_addr, req_size;
   logic [1:0]  req_done;
   logic [1:0]  grant;
   logic        loadEnable;
   logic [15:0] loadAddr;
   logic [15:0] loadSize;
   logic        loadDone;
   logic        busy;
   logic        wd_error;

   int checks = 0;
   int errors = 0;

   assign req_addr = {addr1, addr0};
   assign req_size = {size1, size0};

   load_arbiter #(
      .N_REQ(2), .DATA_SZ(16), .ADDR_SZ(16), .WD_LIMIT(16)
   ) dut (
      .clk(clk), .reset(reset),
      .req_enable(req_enable), .req_addr(req_addr), .req_size(req_size),
      .req_done(req_done), .grant(grant),
      .loadEnable(loadEnable), .loadAddr(loadAddr), .loadSize(loadSize),
      .loadDone(loadDone), .busy(busy), .wd_error(wd_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      logic [1:0]  exp_g;
      logic [15:0] exp_a;

      reset = 1'b1; req_enable = 2'b00; loadDone = 1'b0;
      addr0 = 16'h0; addr1 = 16'h0; size0 = 16'h0; size1 = 16'h0;
      tick(2);
      reset = 1'b0;
      tick(1);

      // Reset state
      check("rst_grant", 32'(grant), 32'h0);
      check("rst_done", 32'(req_done), 32'h0);
      check("rst_len", 32'(loadEnable), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_wd", 32'(wd_error), 32'h0);
      check("rst_addr", 32'(loadAddr), 32'h0);
      check("rst_size", 32'(loadSize), 32'h0);

      // loadDone while idle is ignored
      loadDone = 1'b1;
      tick(1);
      check("idle_done_len", 32'(loadEnable), 32'h0);
      check("idle_done_rd", 32'(req_done), 32'h0);
      loadDone = 1'b0;

      // Single request
      req_enable = 2'b01; addr0 = 16'h0100; size0 = 16'd28;
      tick(1);
      check("single_len", 32'(loadEnable), 32'h1);
      check("single_addr", 32'(loadAddr), 32'h0100);
      check("single_size", 32'(loadSize), 32'd28);
      check("single_grant", 32'(grant), 32'h1);
      check("single_busy", 32'(busy), 32'h1);
      tick(4);
      loadDone = 1'b1;
      tick(1);
      loadDone = 1'b0;
      check("single_rd", 32'(req_done), 32'h1);
      check("single_len_off", 32'(loadEnable), 32'h0);
      tick(1);
      check("single_rd_pulse", 32'(req_done), 32'h0);
      check("single_hold", 32'(grant), 32'h1);
      req_enable = 2'b00;
      tick(1);
      check("single_rel_grant", 32'(grant), 32'h0);
      check("single_rel_busy", 32'(busy), 32'h0);

      // Address stability, then stale level with req1 pending
      req_enable = 2'b01;
      tick(1);
      check("stab_grant", 32'(grant), 32'h1);
      addr0 = 16'h0200; size0 = 16'd99;
      tick(2);
      check("stab_addr", 32'(loadAddr), 32'h0100);
      check("stab_size", 32'(loadSize), 32'd28);
      addr1 = 16'h0A00; size1 = 16'd7;
      req_enable = 2'b11;
      loadDone = 1'b1;
      tick(1);
      loadDone = 1'b0;
      check("stab_rd", 32'(req_done), 32'h1);
      check("stab_addr_end", 32'(loadAddr), 32'h0100);
      for (int i = 0; i < 4; i++) begin
         tick(1);
         check("stale_grant", 32'(grant), 32'h1);
         check("stale_len", 32'(loadEnable), 32'h0);
      end
      req_enable = 2'b10;
      tick(1);
      check("stale_rel_grant", 32'(grant), 32'h0);
      check("stale_rel_busy", 32'(busy), 32'h0);
      tick(1);
      check("stale_next_grant", 32'(grant), 32'h2);
      check("stale_next_addr", 32'(loadAddr), 32'h0A00);
      check("stale_next_size", 32'(loadSize), 32'd7);
      loadDone = 1'b1;
      tick(1);
      loadDone = 1'b0;
      check("stale_next_rd", 32'(req_done), 32'h2);
      req_enable = 2'b00;
      tick(1);
      check("stale_next_rel", 32'(grant), 32'h0);

      // Contention: both keep re-requesting, grants must alternate 01,10,01,10
      addr0 = 16'h1111; addr1 = 16'h2222;
      req_enable = 2'b11;
      for (int k = 0; k < 4; k++) begin
         exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
         exp_a = (k % 2 == 0) ? 16'h1111 : 16'h2222;
         tick(1);
         check("rr_grant", 32'(grant), 32'(exp_g));
         check("rr_addr", 32'(loadAddr), 32'(exp_a));
         tick(2);
         loadDone = 1'b1;
         tick(1);
         loadDone = 1'b0;
         check("rr_rd", 32'(req_done), 32'(exp_g));
         req_enable = 2'b11 & ~exp_g;
         tick(1);
         check("rr_rel", 32'(grant), 32'h0);
         req_enable = 2'b11;
      end
      req_enable = 2'b00;
      tick(1);

      // Reset mid-BUSY (last owner was 1, so req0 wins next)
      req_enable = 2'b01;
      tick(1);
      check("mrst_pre_grant", 32'(grant), 32'h1);
      reset = 1'b1;
      #1;
      check("mrst_grant", 32'(grant), 32'h0);
      check("mrst_len", 32'(loadEnable), 32'h0);
      check("mrst_busy", 32'(busy), 32'h0);
      check("mrst_addr", 32'(loadAddr), 32'h0);
      req_enable = 2'b10;
      @(posedge clk);
      #1;
      reset = 1'b0;
      tick(1);
      check("mrst_req1_grant", 32'(grant), 32'h2);
      check("mrst_req1_addr", 32'(loadAddr), 32'h2222);
      loadDone = 1'b1;
      tick(1);
      loadDone = 1'b0;
      req_enable = 2'b00;
      tick(2);
      check("mrst_idle", 32'(busy), 32'h0);

      // Watchdog
      req_enable = 2'b01; addr0 = 16'h3333;
      tick(1);
      check("wd_start_len", 32'(loadEnable), 32'h1);
`ifdef LOAD_ARB_WATCHDOG_EN
      tick(15);
      check("wd_pre_len", 32'(loadEnable), 32'h1);
      check("wd_pre_err", 32'(wd_error), 32'h0);
      tick(1);
      check("wd_err", 32'(wd_error), 32'h1);
      check("wd_rd", 32'(req_done), 32'h1);
      check("wd_len_off", 32'(loadEnable), 32'h0);
      tick(1);
      check("wd_err_pulse", 32'(wd_error), 32'h0);
      req_enable = 2'b00;
      tick(2);
      req_enable = 2'b01;
      tick(1);
      check("wd2_grant", 32'(grant), 32'h1);
      tick(15);
      loadDone = 1'b1;
      tick(1);
      loadDone = 1'b0;
      check("wd2_err", 32'(wd_error), 32'h0);
      check("wd2_rd", 32'(req_done), 32'h1);
      check("wd2_len_off", 32'(loadEnable), 32'h0);
      tick(1);
      check("wd2_err_after", 32'(wd_error), 32'h0);
`else
      tick(40);
      check("nowd_len", 32'(loadEnable), 32'h1);
      check("nowd_busy", 32'(busy), 32'h1);
      check("nowd_err", 32'(wd_error), 32'h0);
      check("nowd_rd", 32'(req_done), 32'h0);
      loadDone = 1'b1;
      tick(1);
      loadDone = 1'b0;
      check("nowd_done_rd", 32'(req_done), 32'h1);
`endif
      req_enable = 2'b00;
      tick(2);
      check("final_idle", 32'(busy), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
